// File: rtl/noise_pkg.sv
// Shared state encoding, widths and LFSR tap definition for the noise word scheduler.
package noise_pkg;

  localparam int NOISE_W = 16;
  localparam int NUM_REQ = 4;

  // Feedback taps are sreg[0], sreg[2], sreg[3] and sreg[5].
  localparam logic [NOISE_W-1:0] TAP_MASK = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [NOISE_W-1:0] lfsr_step(input logic [NOISE_W-1:0] s);
    return {^(s & TAP_MASK), s[NOISE_W-1:1]};
  endfunction

endpackage

// File: rtl/noise_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping 3 to 0.
module noise_rr_pick
  import noise_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         winner,
  output logic               any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/noise_sched.sv
// Round-robin scheduler handing out fresh 16-bit LFSR noise words; NOISE_SCHED_SEED_LOAD_EN adds runtime reseeding.
// valid pulses 17 edges after req is sampled; a requester holds req until granted, service period 18 cycles.
module noise_sched
  import noise_pkg::*;
#(
  parameter logic [NOISE_W-1:0] SEED    = 16'h0001,
  parameter int                 NUM_REQ = noise_pkg::NUM_REQ
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef NOISE_SCHED_SEED_LOAD_EN
  input  logic                 seed_load,
  input  logic [NOISE_W-1:0]   seed,
`endif
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 valid,
  output logic [NOISE_W-1:0]   data
);

  localparam logic [3:0] CNT_LAST = 4'd15;

  state_t             state;
  state_t             state_nxt;
  logic [NOISE_W-1:0] sreg;
  logic [NOISE_W-1:0] sreg_nxt;
  logic [3:0]         cnt;
  logic [1:0]         ptr;
  logic [1:0]         win;
  logic [1:0]         pick;
  logic               any_req;
  logic               win_latch;
  logic               lfsr_en;
`ifdef NOISE_SCHED_SEED_LOAD_EN
  logic               seed_en;
`endif

  noise_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .any    (any_req)
  );

  assign sreg_nxt = lfsr_step(sreg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    win_latch = 1'b0;
    lfsr_en   = 1'b0;
    valid     = 1'b0;
    grant     = '0;
`ifdef NOISE_SCHED_SEED_LOAD_EN
    seed_en   = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef NOISE_SCHED_SEED_LOAD_EN
        // A reseed wins the cycle; arbitration resumes on the next one.
        if (seed_load) begin
          seed_en = 1'b1;
        end else if (any_req) begin
          win_latch = 1'b1;
          state_nxt = GEN;
        end
`else
        if (any_req) begin
          win_latch = 1'b1;
          state_nxt = GEN;
        end
`endif
      end
      GEN: begin
        lfsr_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        valid      = 1'b1;
        grant[win] = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= SEED;
      cnt  <= '0;
      ptr  <= '0;
      win  <= '0;
      data <= '0;
    end else begin
      if (win_latch) begin
        win <= pick;
        cnt <= '0;
      end
      // The 16th shift completes a word of entirely fresh bits; capture it for DONE.
      if (lfsr_en) begin
        sreg <= sreg_nxt;
        if (cnt != CNT_LAST) begin
          cnt <= cnt + 4'd1;
        end else begin
          data <= sreg_nxt;
        end
      end
      if (valid) begin
        ptr <= win + 2'd1;
      end
`ifdef NOISE_SCHED_SEED_LOAD_EN
      if (seed_en) begin
        sreg <= (seed == '0) ? SEED : seed;
      end
`endif
    end
  end

endmodule

// File: tb/tb_noise_sched.sv
// Directed bench for noise_sched with a service-level reference model checked every cycle.
module tb_noise_sched;

  localparam logic [15:0] SEED = 16'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        valid;
  logic [15:0] data;
`ifdef NOISE_SCHED_SEED_LOAD_EN
  logic        seed_load;
  logic [15:0] seed;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: edges left until the service completes, latched winner, pointer, LFSR, words.
  int m_busy, m_win, m_ptr, m_lfsr, m_word, m_data;
  bit m_found;

  noise_sched #(.SEED(SEED), .NUM_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef NOISE_SCHED_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .req       (req),
    .grant     (grant),
    .valid     (valid),
    .data      (data)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int adv16(input int s);
    int v = s & 16'hFFFF;
    int fb;
    for (int i = 0; i < 16; i++) begin
      fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      v  = (v >> 1) | (fb << 15);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_win  = 0;
    m_ptr  = 0;
    m_lfsr = SEED;
    m_word = 0;
    m_data = 0;
  endtask

  // Compare DUT against the model each cycle, then predict the effect of the coming edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      chk("valid", valid, m_busy == 1);
      chk("grant", grant, (m_busy == 1) ? (1 << m_win) : 0);
      chk("data", data, m_data);
      if (reset) begin
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 1) m_data = m_word;
          if (m_busy == 0) m_ptr = (m_win + 1) % 4;
        end
`ifdef NOISE_SCHED_SEED_LOAD_EN
        else if (seed_load) begin
          m_lfsr = (seed == 16'h0000) ? SEED : seed;
        end
`endif
        else if (req != 4'b0000) begin
          m_found = 0;
          for (int i = 0; i < 4; i++) begin
            if (!m_found && req[(m_ptr + i) % 4]) begin
              m_win   = (m_ptr + i) % 4;
              m_found = 1;
            end
          end
          m_word = adv16(m_lfsr);
          m_lfsr = m_word;
          m_busy = 17;
        end
      end
    end
  end

  task automatic wait_valid(input string name, output int n, output logic [3:0] g,
                            output logic [15:0] d);
    bit seen = 0;
    n = 0;
    g = '0;
    d = '0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (valid) begin
        seen = 1;
        g    = grant;
        d    = data;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: no valid pulse within 40 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          prev;
    int          n_abort;
    logic [3:0]  g;
    logic [15:0] d;
    logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1;
    req   = 4'b0000;
`ifdef NOISE_SCHED_SEED_LOAD_EN
    seed_load = 1'b0;
    seed      = 16'h0000;
`endif
    #3;
    reset = 1'b0;
    req   = 4'b1111;
    repeat (4) begin
      @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_data", data, 0);
    end
    @(posedge clk); #1 reset = 1'b1;

    // All four requesting: strict rotation from index 0, 18-cycle spacing.
    prev = 0;
    for (int s = 0; s < 5; s++) begin
      wait_valid("rr_all", n, g, d);
      chk("rr_grant", g, exp_g[s]);
      if (s > 0) chk("rr_spacing", cyc - prev, 18);
      prev = cyc;
    end
    @(posedge clk); #1 req = 4'b0000;

    // First word after reset, latency from the sampling edge.
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 req = 4'b0001;
    @(posedge clk);
    wait_valid("first_word", n, g, d);
    chk("lat_edges", n, 17);
    chk("first_grant", g, 4'b0001);
    chk("first_data", d, 16'h6801);
    @(posedge clk); #1 req = 4'b0000;

    // Reset at GEN cycle 8 aborts; the reissued request yields the first word again.
    @(posedge clk); #1 req = 4'b0001;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    n_abort = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid) n_abort++;
    end
    chk("abort_valid", n_abort, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    wait_valid("after_abort", n, g, d);
    chk("abort_lat", n, 17);
    chk("abort_grant", g, 4'b0001);
    chk("abort_data", d, 16'h6801);
    @(posedge clk); #1 req = 4'b0000;

    // Winner drops req mid-GEN: still served, pointer moves to 3.
    @(posedge clk); #1 req = 4'b0100;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 req = 4'b0000;
    wait_valid("drop_req", n, g, d);
    chk("drop_grant", g, 4'b0100);
    @(posedge clk); #1 req = 4'b0101;
    @(posedge clk);
    wait_valid("wrap", n, g, d);
    chk("wrap_grant", g, 4'b0001);
    wait_valid("wrap_next", n, g, d);
    chk("wrap_next_grant", g, 4'b0100);
    @(posedge clk); #1 req = 4'b0000;

`ifdef NOISE_SCHED_SEED_LOAD_EN
    // Zero seed falls back to SEED; reseed delays arbitration by one cycle.
    @(posedge clk); #1;
    seed_load = 1'b1;
    seed      = 16'h0000;
    req       = 4'b0010;
    @(posedge clk); #1 seed_load = 1'b0;
    wait_valid("reseed", n, g, d);
    chk("reseed_lat", n, 18);
    chk("reseed_grant", g, 4'b0010);
    chk("reseed_data", d, 16'h6801);
    @(posedge clk); #1 req = 4'b0000;
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
